// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has absolute priority, host writes
// queue in a small FIFO and drain into idle write-port cycles; outputs are registered.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module wb_write_arbiter #(
    parameter int ADDR_W     = `REG_ADDR_WIDTH,
    parameter int DATA_W     = `REG_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              host_hazard,
    output logic              host_busy,
    output logic              wb_stall_req,
    output logic              wena,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    // Host handshake: a write is transferred on a cycle where host_valid && host_ready;
    // host_ready depends only on start-of-cycle occupancy, never on host_valid.
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ST_W-1:0]   r_starve;
    logic              r_wena;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic w_not_empty;
    logic w_push;
    logic w_pop;
    logic w_hazard;

    assign w_not_empty = (r_count != '0);
    assign host_ready  = rst_n && (r_count != CNT_W'(DEPTH));
    assign w_push      = host_valid && host_ready;
    assign w_pop       = !wb_valid && w_not_empty;

    assign host_busy    = w_not_empty;
    assign wb_stall_req = (r_starve == ST_W'(STARVE_MAX));
    assign host_hazard  = w_hazard;
    assign wena         = r_wena;
    assign waddr        = r_waddr;
    assign wdata        = r_wdata;

    // Only entries already queued count; this cycle's push is not yet in r_count.
    always_comb begin
        logic [PTR_W-1:0] off;
        w_hazard = 1'b0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - r_rd_ptr;
            if ((CNT_W'(off) < r_count) &&
                ((r_mem_addr[i] == rd0_addr) || (r_mem_addr[i] == rd1_addr)))
                w_hazard = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= host_addr;
            r_mem_data[r_wr_ptr] <= host_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_wena   <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_pop || !w_not_empty)
                r_starve <= '0;
            else if (wb_valid && (r_starve != ST_W'(STARVE_MAX)))
                r_starve <= r_starve + ST_W'(1);

            // Pipeline always wins; idle cycles drain the FIFO head.
            if (wb_valid) begin
                r_wena  <= 1'b1;
                r_waddr <= wb_addr;
                r_wdata <= wb_data;
            end else if (w_not_empty) begin
                r_wena  <= 1'b1;
                r_waddr <= r_mem_addr[r_rd_ptr];
                r_wdata <= r_mem_data[r_rd_ptr];
            end else begin
                r_wena  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: reset, pipeline path, host path, full/starve drain,
// hazard flag and reset during a drain, with hand-computed expectations.
module tb_wb_write_arbiter;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 64;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic              clk;
    logic              rst_n;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic [ADDR_W-1:0] rd0_addr;
    logic [ADDR_W-1:0] rd1_addr;
    logic              host_hazard;
    logic              host_busy;
    logic              wb_stall_req;
    logic              wena;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    int n_vec;
    int n_err;
    logic [ADDR_W-1:0] exp_q[$];

    wb_write_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .host_hazard(host_hazard), .host_busy(host_busy), .wb_stall_req(wb_stall_req),
        .wena(wena), .waddr(waddr), .wdata(wdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 64'hDEAD;
        host_valid = 1'b1; host_addr = 4'd6; host_data = 64'hBEEF;
        rd0_addr = 4'd0; rd1_addr = 4'd0;

        // reset held 3 cycles with both sources active
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_wena", 64'(wena), 64'd0);
            check_val("rst_ready", 64'(host_ready), 64'd0);
        end
        check_val("rst_waddr", 64'(waddr), 64'd0);
        check_val("rst_wdata", wdata, 64'd0);
        rst_n = 1'b1; wb_valid = 1'b0; host_valid = 1'b0;
        #1;
        check_val("post_rst_ready", 64'(host_ready), 64'd1);
        check_val("post_rst_busy", 64'(host_busy), 64'd0);
        check_val("post_rst_stall", 64'(wb_stall_req), 64'd0);
        tick();
        check_val("post_rst_wena", 64'(wena), 64'd0);
        check_val("post_rst_busy2", 64'(host_busy), 64'd0);

        // pipeline path
        wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 64'hA5;
        tick();
        wb_valid = 1'b0;
        check_val("wb_wena", 64'(wena), 64'd1);
        check_val("wb_waddr", 64'(waddr), 64'd3);
        check_val("wb_wdata", wdata, 64'hA5);
        tick();
        check_val("wb_idle_wena", 64'(wena), 64'd0);
        check_val("wb_idle_waddr_hold", 64'(waddr), 64'd3);

        // host path: push at t, write visible at t+2
        host_valid = 1'b1; host_addr = 4'd7; host_data = 64'h1234;
        #1;
        check_val("host_ready_idle", 64'(host_ready), 64'd1);
        check_val("host_busy_t", 64'(host_busy), 64'd0);
        tick();
        host_valid = 1'b0;
        check_val("host_busy_t1", 64'(host_busy), 64'd1);
        check_val("host_wena_t1", 64'(wena), 64'd0);
        tick();
        check_val("host_wena_t2", 64'(wena), 64'd1);
        check_val("host_waddr_t2", 64'(waddr), 64'd7);
        check_val("host_wdata_t2", wdata, 64'h1234);
        check_val("host_busy_t2", 64'(host_busy), 64'd0);
        tick();
        check_val("host_wena_t3", 64'(wena), 64'd0);

        // full / starve: pipeline busy every cycle, host pushes addrs 1..5
        wb_valid = 1'b1; wb_addr = 4'hF; wb_data = 64'hF0F0;
        for (int k = 1; k <= 4; k++) begin
            host_valid = 1'b1; host_addr = ADDR_W'(k); host_data = 64'(k) * 64'h11;
            #1;
            check_val("fill_ready", 64'(host_ready), 64'd1);
            tick();
        end
        host_addr = 4'd5; host_data = 64'h55;
        for (int cyc = 4; cyc <= 9; cyc++) begin
            check_val("full_ready", 64'(host_ready), 64'd0);
            check_val("full_stall", 64'(wb_stall_req), (cyc == 9) ? 64'd1 : 64'd0);
            check_val("full_pipe_wins", 64'(waddr), 64'hF);
            tick();
        end
        check_val("stall_sat", 64'(wb_stall_req), 64'd1);
        check_val("full_ready_c10", 64'(host_ready), 64'd0);
        wb_valid = 1'b0;
        for (int k = 1; k <= 5; k++) exp_q.push_back(ADDR_W'(k));
        tick();
        check_val("stall_fall", 64'(wb_stall_req), 64'd0);
        check_val("ready_after_pop", 64'(host_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            a = exp_q.pop_front();
            check_val("drain_wena", 64'(wena), 64'd1);
            check_val("drain_waddr", 64'(waddr), 64'(a));
            check_val("drain_wdata", wdata, 64'(a) * 64'h11);
            tick();
            host_valid = 1'b0;
        end
        check_val("drain_done_wena", 64'(wena), 64'd0);
        check_val("drain_done_busy", 64'(host_busy), 64'd0);

        // hazard
        wb_valid = 1'b1; wb_addr = 4'hE; wb_data = 64'hE;
        host_valid = 1'b1; host_addr = 4'd5; host_data = 64'h5555;
        rd0_addr = 4'd5; rd1_addr = 4'd2;
        #1;
        check_val("haz_push_excl", 64'(host_hazard), 64'd0);
        tick();
        host_valid = 1'b0;
        #1;
        check_val("haz_rd0", 64'(host_hazard), 64'd1);
        rd0_addr = 4'd9; rd1_addr = 4'd5;
        #1;
        check_val("haz_rd1", 64'(host_hazard), 64'd1);
        rd0_addr = 4'd9; rd1_addr = 4'd2;
        #1;
        check_val("haz_nomatch", 64'(host_hazard), 64'd0);
        rd0_addr = 4'd5; rd1_addr = 4'd2;
        tick();
        check_val("haz_still", 64'(host_hazard), 64'd1);
        wb_valid = 1'b0;
        #1;
        check_val("haz_pop_cycle", 64'(host_hazard), 64'd1);
        tick();
        check_val("haz_after_pop", 64'(host_hazard), 64'd0);
        check_val("haz_wr_addr", 64'(waddr), 64'd5);
        check_val("haz_wr_data", wdata, 64'h5555);
        tick();

        // reset in the middle of a drain
        wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 64'h0;
        for (int k = 10; k <= 12; k++) begin
            host_valid = 1'b1; host_addr = ADDR_W'(k); host_data = 64'(k);
            tick();
        end
        host_valid = 1'b0; wb_valid = 1'b0;
        tick();
        check_val("mid_first_pop", 64'(waddr), 64'd10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("mid_rst_wena", 64'(wena), 64'd0);
        check_val("mid_rst_busy", 64'(host_busy), 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("mid_rst_no_write", 64'(wena), 64'd0);
            check_val("mid_rst_busy_after", 64'(host_busy), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Write-port arbiter and register stage directly upstream of the register file's single write port (wena/waddr/wdata).
- Merges two write sources:
  - the pipeline writeback, which always wins and has no backpressure;
  - host/debug register-write commands, which are buffered in a small FIFO and drained into idle write-port cycles.
- Flags decode-stage reads that hit a queued host write.
- Requests a pipeline bubble when host writes starve.

Parameters:
- ADDR_W, `REG_ADDR_WIDTH: register address width.
- DATA_W, `REG_DATA_WIDTH: register data width.
- DEPTH, 4: host FIFO entries; power of two, at least 2.
- STARVE_MAX, 8: consecutive denied cycles before wb_stall_req asserts.

Ports:
- clk  in  1: clock; all state updates on posedge.
- rst_n  in  1: synchronous active-low reset.
- wb_valid  in  1: pipeline writeback valid; always accepted.
- wb_addr  in  ADDR_W: pipeline destination register.
- wb_data  in  DATA_W: pipeline write data.
- host_valid  in  1: host write request.
- host_ready  out  1: FIFO can accept this cycle.
- host_addr  in  ADDR_W: host destination register.
- host_data  in  DATA_W: host write data.
- rd0_addr  in  ADDR_W: decode-stage source register 0.
- rd1_addr  in  ADDR_W: decode-stage source register 1.
- host_hazard  out  1: a queued host write targets rd0_addr or rd1_addr.
- host_busy  out  1: FIFO non-empty.
- wb_stall_req  out  1: request the pipeline to hold wb_valid low.
- wena  out  1: registered write enable to the register file.
- waddr  out  ADDR_W: registered write address.
- wdata  out  DATA_W: registered write data.

Behaviour:
- Reset (rst_n=0 at posedge):
  - wena=0, waddr=0, wdata=0.
  - FIFO count, read pointer and write pointer = 0; FIFO contents discarded.
  - Starve counter = 0; wb_stall_req=0.
  - host_ready=0 while rst_n=0, then 1 in the first cycle after release.
  - Reset mid-operation drops queued entries and the in-flight output write, so wena=0 in the cycle after the reset edge.
- FIFO:
  - host_ready = rst_n && (count != DEPTH), computed from count at the start of the cycle.
  - When full, no push is accepted even if a pop happens in the same cycle.
  - Push on host_valid && host_ready.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - A push and a pop in the same cycle leave count unchanged.
- Arbitration, evaluated per cycle and registered (1-cycle latency to wena/waddr/wdata):
  - If wb_valid: next wena=1, waddr=wb_addr, wdata=wb_data; no pop.
  - Else if count != 0: pop the head; next wena=1, waddr/wdata = head entry.
  - Else: next wena=0; waddr/wdata hold their previous values.
- Bypass rule: an entry pushed this cycle is not poppable until the next cycle. Minimum host latency is push cycle to wena = 2 cycles.
- Ordering:
  - Host writes commit in FIFO order.
  - Commit order between sources equals grant order.
  - If both sources write the same register, the later-granted write persists.
- Starvation:
  - Starve counter increments (saturating at STARVE_MAX) each cycle with count != 0 && wb_valid.
  - It clears on any pop, or when count==0.
  - wb_stall_req = (starve counter == STARVE_MAX), a registered-state decode.
  - If wb_valid stays high anyway, the pipeline still wins; no data is lost.
- Hazard:
  - host_hazard is combinational: OR over valid FIFO entries of (entry.addr == rd0_addr || entry.addr == rd1_addr).
  - The entry being pushed this cycle is excluded.
  - The entry in the output register is excluded; the register file forwards it.
- host_busy = (count != 0).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with wb_valid=1 and host_valid=1 -> wena=0 and host_ready=0 throughout; after release, host_ready=1, and nothing was queued.
- Pipeline path (ADDR_W=4, DATA_W=64): wb_valid=1, wb_addr=3, wb_data=0xA5 at cycle t -> at t+1, wena=1, waddr=3, wdata=0xA5; at t+2 with wb_valid=0 and FIFO empty -> wena=0.
- Host path: single push addr=7, data=0x1234 at t with the port idle -> wena=1, waddr=7, wdata=0x1234 at t+2; host_busy=1 only during cycle t+1.
- Full/starve (STARVE_MAX=8): wb_valid held 1; host pushes 5 writes to addrs 1..5 on consecutive cycles:
  - the first 4 are accepted; host_ready=0 from the cycle after the 4th push; the 5th is held by the host;
  - wb_stall_req=1 after 8 denied cycles;
  - then wb_valid=0 -> wena shows addrs 1,2,3,4 on 4 consecutive cycles, each entry popped on the cycle before its wena;
  - host_ready=1 from the cycle after the first pop, after which addr 5 is pushed;
  - wb_stall_req falls the cycle after the first pop.
- Hazard: queue a host write to addr 5 while wb_valid=1, and set rd0_addr=5, rd1_addr=2 -> host_hazard=1; the entry is popped at cycle p -> host_hazard=0 from cycle p+1.
- Reset mid-drain: 3 entries queued, rst_n=0 for one cycle after the first pop -> wena=0 the next cycle; host_busy=0; none of the remaining entries is ever written.
